i2c_slave_regs: RTL and testbench

I2C target with an 8-byte register file for the dice project, wired to the bidirectional pins (SDA uio[2], SCL uio[3]).
- Decodes START, STOP and repeated START, and matches a 7-bit address.
- Writes take a sub-address pointer followed by data bytes; reads stream bytes from the pointer. The pointer auto-increments in both directions.
- Register contents drive downstream dice/display configuration. Open-drain SDA output feeds uio_out[2]/uio_oe[2].

---
 rtl/i2c_slave_regs_if.sv | 11 +
 rtl/i2c_slave_regs.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_regs_if.sv
// I2C pin bundle between a bus master (or pad wrapper) and the register-file target.
// SDA is open-drain: the target only ever pulls low through sda_oe.
`timescale 1ns/1ps
interface i2c_slave_regs_if;
  logic sda_in;
  logic scl_in;
  logic sda_oe;

  modport master (output sda_in, output scl_in, input sda_oe);
  modport slave  (input sda_in, input scl_in, output sda_oe);
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C target with a small register file: START/STOP/repeated-START decode, 7-bit address
// match, sub-address pointer with auto-increment, streaming reads and writes.
`timescale 1ns/1ps
module i2c_slave_regs #(
  parameter logic [6:0] ADDR       = 7'h70,
  parameter int         NREGS_LOG2 = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  i2c_slave_regs_if.slave                  bus,
  output logic [8*(2**NREGS_LOG2)-1:0]     regs,
  output logic                             wr_pulse,
  output logic [NREGS_LOG2-1:0]            wr_idx,
  output logic                             busy
);

  localparam int NR = 2**NREGS_LOG2;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_SUB, S_SUB_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_sda_s1, r_sda_s2, r_sda_h;
  logic                  r_scl_s1, r_scl_s2, r_scl_h;
  logic [7:0]            r_shift;
  logic [2:0]            r_bitcnt;
  logic [NREGS_LOG2-1:0] r_ptr;
  logic [7:0]            r_regs [NR];
  logic                  r_rw;
  logic                  r_ack_rose;
  logic                  r_sda_oe;
  logic                  r_busy;
  logic                  r_wr_pulse;
  logic [NREGS_LOG2-1:0] r_wr_idx;

  logic                  w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]            w_byte;
  logic                  w_last;
  logic                  w_shift_en, w_match, w_ptr_load, w_wr;
  logic                  w_ack_rise, w_rd_load, w_oe_upd, w_oe_val;

  // Two-flop synchronisers plus one history flop; idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_h  <= 1'b1;
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_h  <= 1'b1;
    end else begin
      r_sda_s1 <= bus.sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_h  <= r_sda_s2;
      r_scl_s1 <= bus.scl_in;
      r_scl_s2 <= r_scl_s1;
      r_scl_h  <= r_scl_s2;
    end
  end

  // Bus conditions only need SCL high now, so they beat a coincident SCL rise.
  assign w_scl_rise = r_scl_s2 & ~r_scl_h;
  assign w_scl_fall = ~r_scl_s2 & r_scl_h;
  assign w_start    = r_scl_s2 & r_sda_h & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & ~r_sda_h & r_sda_s2;
  assign w_byte     = {r_shift[6:0], r_sda_s2};
  assign w_last     = (r_bitcnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = S_ADDR;
    end else if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_scl_rise) begin
      case (r_state)
        S_ADDR:      if (w_last) w_state_nxt = (w_byte[7:1] == ADDR) ? S_ADDR_ACK : S_IDLE;
        S_SUB:       if (w_last) w_state_nxt = S_SUB_ACK;
        S_WDATA:     if (w_last) w_state_nxt = S_WDATA_ACK;
        S_RDATA:     if (w_last) w_state_nxt = S_RDATA_ACK;
        S_RDATA_ACK: if (r_sda_s2) w_state_nxt = S_IDLE;
        default:     ;
      endcase
    end else if (w_scl_fall && r_ack_rose) begin
      case (r_state)
        S_ADDR_ACK:               w_state_nxt = r_rw ? S_RDATA : S_SUB;
        S_SUB_ACK, S_WDATA_ACK:   w_state_nxt = S_WDATA;
        S_RDATA_ACK:              w_state_nxt = S_RDATA;
        default:                  ;
      endcase
    end
  end

  // SDA is only ever re-decided on an SCL falling edge (or released on START/STOP).
  always_comb begin
    w_shift_en = 1'b0;
    w_match    = 1'b0;
    w_ptr_load = 1'b0;
    w_wr       = 1'b0;
    w_ack_rise = 1'b0;
    w_rd_load  = 1'b0;
    w_oe_upd   = 1'b0;
    w_oe_val   = 1'b0;
    if (w_start || w_stop) begin
      w_oe_upd = 1'b1;
    end else if (w_scl_rise) begin
      case (r_state)
        S_ADDR: begin
          w_shift_en = 1'b1;
          w_match    = w_last && (w_byte[7:1] == ADDR);
        end
        S_SUB: begin
          w_shift_en = 1'b1;
          w_ptr_load = w_last;
        end
        S_WDATA: begin
          w_shift_en = 1'b1;
          w_wr       = w_last;
        end
        S_RDATA:                              w_shift_en = 1'b1;
        S_ADDR_ACK, S_SUB_ACK, S_WDATA_ACK:   w_ack_rise = 1'b1;
        S_RDATA_ACK:                          w_ack_rise = ~r_sda_s2;
        default:                              ;
      endcase
    end else if (w_scl_fall) begin
      w_oe_upd = 1'b1;
      case (r_state)
        S_ADDR_ACK: begin
          if (!r_ack_rose) begin
            w_oe_val = 1'b1;
          end else if (r_rw) begin
            w_rd_load = 1'b1;
            w_oe_val  = ~r_regs[r_ptr][7];
          end
        end
        S_SUB_ACK, S_WDATA_ACK: w_oe_val = ~r_ack_rose;
        S_RDATA:                w_oe_val = ~r_shift[7];
        S_RDATA_ACK: begin
          if (r_ack_rose) begin
            w_rd_load = 1'b1;
            w_oe_val  = ~r_regs[r_ptr][7];
          end
        end
        default:                ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_ptr      <= '0;
      r_rw       <= 1'b0;
      r_ack_rose <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_idx   <= '0;
      for (int i = 0; i < NR; i++) r_regs[i] <= '0;
    end else begin
      if (w_rd_load)       r_shift <= r_regs[r_ptr];
      else if (w_shift_en) r_shift <= w_byte;

      if (w_start || (w_state_nxt != r_state)) r_bitcnt <= '0;
      else if (w_shift_en)                     r_bitcnt <= r_bitcnt + 3'd1;

      if (w_start || (w_state_nxt != r_state)) r_ack_rose <= 1'b0;
      else if (w_ack_rise)                     r_ack_rose <= 1'b1;

      if (w_ptr_load)             r_ptr <= w_byte[NREGS_LOG2-1:0];
      else if (w_wr || w_rd_load) r_ptr <= r_ptr + 1'b1;

      if (w_wr) begin
        r_regs[r_ptr] <= w_byte;
        r_wr_idx      <= r_ptr;
      end
      r_wr_pulse <= w_wr;

      if (w_match) r_rw <= w_byte[0];

      if (w_start || w_stop) r_busy <= 1'b0;
      else if (w_match)      r_busy <= 1'b1;

      if (w_oe_upd) r_sda_oe <= w_oe_val;
    end
  end

  always_comb begin
    regs = '0;
    for (int i = 0; i < NR; i++) regs[8*i +: 8] = r_regs[i];
  end

  assign bus.sda_oe = r_sda_oe;
  assign wr_pulse   = r_wr_pulse;
  assign wr_idx     = r_wr_idx;
  assign busy       = r_busy;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged I2C master on an open-drain SDA line,
// a table of write transactions plus hand-written read, bad-address, NACK and reset sequences.
`timescale 1ns/1ps
module tb_i2c_slave_regs;
  localparam int Q = 10;  // quarter SCL period in clk cycles (SCL = clk/40)

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda_low = 1'b0;
  logic [63:0] regs;
  logic        wr_pulse;
  logic [2:0]  wr_idx;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  i2c_slave_regs_if bus();
  assign bus.scl_in = m_scl;
  assign bus.sda_in = ~(m_sda_low | bus.sda_oe);

  i2c_slave_regs #(.ADDR(7'h70), .NREGS_LOG2(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .regs     (regs),
    .wr_pulse (wr_pulse),
    .wr_idx   (wr_idx),
    .busy     (busy)
  );

  logic [2:0] wlog[$];
  int         busy_cnt = 0;
  int         oe_cnt = 0;
  always @(negedge clk) begin
    if (wr_pulse) wlog.push_back(wr_idx);
    if (busy) busy_cnt++;
    if (bus.sda_oe) oe_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic qwait();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; qwait();
    m_scl = 1'b1;     qwait();
    m_sda_low = 1'b1; qwait();
    m_scl = 1'b0;     qwait();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; qwait();
    m_scl = 1'b1;     qwait();
    m_sda_low = 1'b0; qwait();
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; qwait();
    m_scl = 1'b1;   qwait(); qwait();
    m_scl = 1'b0;   qwait();
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; qwait();
    m_scl = 1'b1;     qwait();
    b = bus.sda_in;   qwait();
    m_scl = 1'b0;     qwait();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack_n);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  typedef struct {
    logic [7:0]  sub;
    int          n;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [63:0] exp_regs;
  } wvec_t;

  wvec_t wv [4];

  task automatic apply_wvec(input int i);
    logic ack_n;
    int   base;
    base = wlog.size();
    i2c_start();
    write_byte(8'hE0, ack_n);
    chk($sformatf("wv%0d addr ack", i), ack_n, 0);
    chk($sformatf("wv%0d busy", i), busy, 1);
    write_byte(wv[i].sub, ack_n);
    chk($sformatf("wv%0d sub ack", i), ack_n, 0);
    write_byte(wv[i].d0, ack_n);
    chk($sformatf("wv%0d d0 ack", i), ack_n, 0);
    if (wv[i].n > 1) begin
      write_byte(wv[i].d1, ack_n);
      chk($sformatf("wv%0d d1 ack", i), ack_n, 0);
    end
    i2c_stop();
    qwait();
    chk($sformatf("wv%0d busy after stop", i), busy, 0);
    chk($sformatf("wv%0d regs", i), regs, wv[i].exp_regs);
    chk($sformatf("wv%0d pulse count", i), 64'(wlog.size() - base), 64'(wv[i].n));
    for (int k = 0; k < wv[i].n && base + k < wlog.size(); k++)
      chk($sformatf("wv%0d wr_idx %0d", i, k), wlog[base + k], 3'((wv[i].sub + 8'(k)) & 8'h07));
  endtask

  initial begin
    logic       ack_n;
    logic       got;
    logic [7:0] d;
    int         base, b0, o0;
    logic [7:0] rd_exp [8];

    wv[0] = '{sub: 8'h00, n: 2, d0: 8'hAA, d1: 8'h55, exp_regs: 64'h0000_0000_0000_55AA};
    wv[1] = '{sub: 8'h02, n: 2, d0: 8'h69, d1: 8'h96, exp_regs: 64'h0000_0000_9669_55AA};
    wv[2] = '{sub: 8'h04, n: 2, d0: 8'h33, d1: 8'hFF, exp_regs: 64'h0000_FF33_9669_55AA};
    wv[3] = '{sub: 8'h0F, n: 2, d0: 8'h11, d1: 8'h22, exp_regs: 64'h1100_FF33_9669_5522};
    rd_exp = '{8'hAA, 8'h55, 8'h69, 8'h96, 8'h33, 8'hFF, 8'h00, 8'h00};

    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    qwait();
    chk("reset sda_oe", bus.sda_oe, 0);
    chk("reset regs", regs, 0);
    chk("reset wr_pulse", wr_pulse, 0);
    chk("reset wr_idx", wr_idx, 0);
    chk("reset busy", busy, 0);

    for (int i = 0; i < 3; i++) apply_wvec(i);

    // Sub-address write, repeated START, read all eight bytes with ACK.
    base = wlog.size();
    i2c_start();
    write_byte(8'hE0, ack_n); chk("rd addr w ack", ack_n, 0);
    write_byte(8'h00, ack_n); chk("rd sub ack", ack_n, 0);
    i2c_start();
    write_byte(8'hE1, ack_n); chk("rd addr r ack", ack_n, 0);
    for (int k = 0; k < 8; k++) begin
      read_byte(d, 1'b0);
      chk($sformatf("rd byte %0d", k), d, rd_exp[k]);
    end
    i2c_stop();
    qwait();
    chk("rd no wr_pulse", 64'(wlog.size() - base), 0);
    chk("rd regs intact", regs, wv[2].exp_regs);

    // Wrong address: nothing acknowledged, nothing written, never busy.
    b0 = busy_cnt;
    o0 = oe_cnt;
    i2c_start();
    write_byte(8'hE2, ack_n); chk("bad addr nak", ack_n, 1);
    write_byte(8'h00, ack_n); chk("bad sub nak", ack_n, 1);
    write_byte(8'h12, ack_n); chk("bad data nak", ack_n, 1);
    i2c_stop();
    qwait();
    chk("bad regs unchanged", regs, wv[2].exp_regs);
    chk("bad busy never", 64'(busy_cnt - b0), 0);
    chk("bad sda never driven", 64'(oe_cnt - o0), 0);

    // Pointer wrap on write, then a single-byte read ended by NACK.
    apply_wvec(3);
    i2c_start();
    write_byte(8'hE1, ack_n); chk("nack addr ack", ack_n, 0);
    read_byte(d, 1'b1);       chk("nack read byte1", d, 8'h55);
    qwait();
    chk("nack sda released", bus.sda_oe, 0);
    read_byte(d, 1'b1);       chk("nack idle bus floats", d, 8'hFF);
    i2c_stop();
    qwait();
    chk("nack busy after stop", busy, 0);

    // Reset while the target is pulling SDA for the address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(((8'hE0 >> i) & 8'h01) != 8'h00);
    m_sda_low = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(posedge clk);
      #1;
      if (bus.sda_oe) got = 1'b1;
    end
    chk("rst ack driven", got, 1);
    rst_n = 1'b0;
    #1;
    chk("rst sda_oe immediate", bus.sda_oe, 0);
    chk("rst regs cleared", regs, 0);
    chk("rst busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    i2c_stop();
    qwait();
    apply_wvec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
